// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle line-wide data memory responder
//
// Accepts one line read or write, holds it for LATENCY cycles, then
// completes it with a one-cycle acknowledge. Only one request is in flight.
//
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   rst_i   : synchronous active-high reset
//   req_i   : request valid, held with its fields until ack_o is seen
//   we_i    : 1 = write, 0 = read
//   addr_i  : byte address; line index = addr_i >> log2(DATA_W/8), mod DEPTH
//   data_i  : write line
//   ack_o   : one-cycle completion pulse
//   data_o  : read (or just-written) line, held from one ack to the next
//   busy_o  : high from acceptance through the acknowledge cycle
module dmem_responder #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // WAIT exits once the counter reaches LATENCY-2; irrelevant when LATENCY=1.
  localparam logic [CNT_W-1:0] CNT_LAST = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;

  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_q;

  logic [IDX_W-1:0]   line_idx;
  logic               unused_addr;

  // Request fields used by the access that happens on the edge entering ACK.
  // From IDLE (LATENCY=1) the latch has not been loaded yet, so the live
  // inputs are used instead of the held copy.
  logic               acc_we;
  logic [IDX_W-1:0]   acc_idx;
  logic [DATA_W-1:0]  acc_data;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Byte offset and bits above the array size are dropped, so addresses
  // alias modulo DEPTH lines.
  assign line_idx    = addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^{addr_i[31:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_we   = we_q;
    acc_idx  = idx_q;
    acc_data = data_q;
    unique case (state)
      ST_IDLE: begin
        acc_we   = we_i;
        acc_idx  = line_idx;
        acc_data = data_i;
        cnt_d    = '0;
        if (req_i) begin
          if (LATENCY == 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ack_o  <= 1'b0;
      busy_o <= 1'b0;
      data_o <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ack_o  <= (state_d == ST_ACK);
      busy_o <= (state_d != ST_IDLE);
      if (state == ST_IDLE && req_i) begin
        we_q   <= we_i;
        idx_q  <= line_idx;
        data_q <= data_i;
      end
      if (state_d == ST_ACK) begin
        data_o <= acc_we ? acc_data : mem[acc_idx];
      end
    end
  end

  // Array has no reset; a write commits only on the edge entering ACK, so a
  // reset during WAIT drops it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_d == ST_ACK && acc_we) begin
      mem[acc_idx] <= acc_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder at LATENCY 10 and 1
module tb_dmem_responder;

  localparam int DW   = 256;
  localparam int DEP  = 512;
  localparam int LB   = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [1:0]     req;
  logic [1:0]     we;
  logic [31:0]    addr  [2];
  logic [DW-1:0]  wdata [2];
  logic [1:0]     ack;
  logic [1:0]     busy;
  logic [DW-1:0]  rdata [2];

  dmem_responder #(.DATA_W(DW), .DEPTH(DEP), .LATENCY(10)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .ack_o(ack[0]), .data_o(rdata[0]), .busy_o(busy[0])
  );

  dmem_responder #(.DATA_W(DW), .DEPTH(DEP), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .ack_o(ack[1]), .data_o(rdata[1]), .busy_o(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: memory contents plus "request outstanding, cycles left".
  logic [DW-1:0] mm [2][DEP];
  bit            m_pend [2];
  int            m_rem  [2];
  bit            m_we   [2];
  int            m_idx  [2];
  logic [DW-1:0] m_data [2];
  bit            e_ack  [2];
  bit            e_busy [2];
  logic [DW-1:0] e_data [2];

  function automatic int lat_of(input int c);
    return (c == 0) ? 10 : 1;
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void finish_access(input int c);
    if (m_we[c]) begin
      mm[c][m_idx[c]] = m_data[c];
      e_data[c] = m_data[c];
    end else begin
      e_data[c] = mm[c][m_idx[c]];
    end
    e_ack[c] = 1'b1;
  endfunction

  // Model update on each rising edge from the inputs seen at that edge.
  initial forever begin
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_pend[c] = 1'b0;
        e_ack[c]  = 1'b0;
        e_busy[c] = 1'b0;
        e_data[c] = '0;
      end else if (e_ack[c]) begin
        e_ack[c]  = 1'b0;
        e_busy[c] = 1'b0;
      end else if (m_pend[c]) begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          m_pend[c] = 1'b0;
          finish_access(c);
        end
      end else if (req[c]) begin
        m_we[c]   = we[c];
        m_idx[c]  = int'((addr[c] / 32'(LB)) % 32'(DEP));
        m_data[c] = wdata[c];
        e_busy[c] = 1'b1;
        if (lat_of(c) == 1) begin
          finish_access(c);
        end else begin
          m_pend[c] = 1'b1;
          m_rem[c]  = lat_of(c) - 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        chk_i($sformatf("ack%0d", c), int'(ack[c]), int'(e_ack[c]));
        chk_i($sformatf("busy%0d", c), int'(busy[c]), int'(e_busy[c]));
        chk_w($sformatf("data%0d", c), rdata[c], e_data[c]);
      end
    end
  end

  // One full request; lat = cycles from the acceptance cycle to the ack cycle.
  task automatic txn(input int c, input bit w, input logic [31:0] a,
                     input logic [DW-1:0] d, input bit jitter,
                     output logic [DW-1:0] q, output int lat);
    @(negedge clk);
    req[c]   = 1'b1;
    we[c]    = w;
    addr[c]  = a;
    wdata[c] = d;
    lat = -1;
    q   = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[c]) begin
        lat = n;
        q   = rdata[c];
        break;
      end
      if (jitter) begin
        req[c]   = 1'($urandom_range(0, 1));
        we[c]    = 1'($urandom_range(0, 1));
        addr[c]  = $urandom;
        wdata[c] = rnd_line();
      end
    end
    req[c] = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout%0d: got no ack want ack", c);
    end
  endtask

  // Start a request and kill it with reset k cycles after acceptance.
  task automatic abort_txn(input int c, input bit w, input logic [31:0] a,
                           input logic [DW-1:0] d, input int k);
    @(negedge clk);
    req[c]   = 1'b1;
    we[c]    = w;
    addr[c]  = a;
    wdata[c] = d;
    repeat (k) @(negedge clk);
    rst    = 1'b1;
    req[c] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q;
    int            lat;
    int            n;
    int            nb;
    int            c;
    int            line;
    int            al;
    bit            w;
    logic [31:0]   a;

    rst = 1'b1;
    req = '0;
    we  = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk_i("rst_ack0", int'(ack[0]), 0);
    chk_i("rst_busy0", int'(busy[0]), 0);
    chk_w("rst_data0", rdata[0], '0);
    chk_w("rst_data1", rdata[1], '0);
    rst = 1'b0;

    // Write then read line 2, latency 10.
    txn(0, 1'b1, 32'h40, {32{8'hA5}}, 1'b0, q, lat);
    chk_i("t1_wlat", lat, 10);
    txn(0, 1'b0, 32'h40, '0, 1'b0, q, lat);
    chk_i("t1_rlat", lat, 10);
    chk_w("t1_rdata", q, {32{8'hA5}});

    // Request held through ACK: not re-accepted in ACK, accepted from IDLE.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
    n = 0;
    while (!ack[0] && n < 40) begin @(negedge clk); n++; end
    chk_i("t2_lat1", n, 10);
    @(negedge clk);
    chk_i("t2_idle_busy", int'(busy[0]), 0);
    chk_i("t2_idle_ack", int'(ack[0]), 0);
    @(negedge clk);
    chk_i("t2_rebusy", int'(busy[0]), 1);
    req[0] = 1'b0;
    n = 1;
    while (!ack[0] && n < 40) begin @(negedge clk); n++; end
    chk_i("t2_lat2", n, 10);

    // Reset in WAIT cycle 4 drops a write to line 5.
    txn(0, 1'b1, 32'hA0, {32{8'h11}}, 1'b0, q, lat);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hA0; wdata[0] = {32{8'hFF}};
    repeat (4) @(negedge clk);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_i("t3_busy", int'(busy[0]), 0);
    chk_w("t3_data", rdata[0], '0);
    nb = 0;
    repeat (12) begin @(negedge clk); nb += int'(ack[0]); end
    chk_i("t3_noack", nb, 0);
    txn(0, 1'b0, 32'hA0, '0, 1'b0, q, lat);
    chk_w("t3_rdata", q, {32{8'h11}});

    // Address wrap: line 512 aliases line 0.
    txn(0, 1'b1, 32'h4000, 256'h1234, 1'b0, q, lat);
    txn(0, 1'b0, 32'h0, '0, 1'b0, q, lat);
    chk_w("t4_wrap", q, 256'h1234);

    // LATENCY=1 instance.
    txn(1, 1'b1, 32'hE0, 256'hDEADBEEF_0123, 1'b0, q, lat);
    chk_i("t5_wlat", lat, 1);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'hE0;
    @(negedge clk);
    req[1] = 1'b0;
    chk_i("t5_ack", int'(ack[1]), 1);
    chk_w("t5_data", rdata[1], 256'hDEADBEEF_0123);
    nb = int'(busy[1]);
    repeat (3) begin @(negedge clk); nb += int'(busy[1]); end
    chk_i("t5_busy_cycles", nb, 1);

    // Inputs toggled mid-WAIT do not disturb the access.
    txn(0, 1'b1, 32'h60, 256'hBEEF_CAFE, 1'b1, q, lat);
    txn(0, 1'b0, 32'h60, '0, 1'b1, q, lat);
    chk_i("t5_jit_lat", lat, 10);
    chk_w("t5_jit_data", q, 256'hBEEF_CAFE);

    // Fill lines 0..15 on both instances so random reads are defined.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        txn(k, 1'b1, 32'(i * LB), rnd_line(), 1'b0, q, lat);
      end
    end

    // Random traffic with aliasing, byte offsets, jitter and aborts.
    for (int k = 0; k < 80; k++) begin
      c    = int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      line = int'($urandom_range(0, 15));
      al   = int'($urandom_range(0, 7));
      a    = 32'((al * DEP + line) * LB) + 32'($urandom_range(0, LB - 1));
      if (k % 13 == 6) begin
        abort_txn(c, w, a, rnd_line(), int'($urandom_range(1, 9)));
      end else begin
        txn(c, w, a, rnd_line(), 1'($urandom_range(0, 1)), q, lat);
        chk_i("rand_lat", lat, lat_of(c));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
